// File: rtl/pri_arbiter_rr.sv
// Registered N-way arbiter: fixed (highest index wins) or round-robin selection,
// grant held until the owner pulses done or drops its request.
module pri_arbiter_rr #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         done,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_oh
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         mode_q, mode_d;
    logic         gnt_valid_q, gnt_valid_d;
    logic [W-1:0] gnt_idx_q, gnt_idx_d;
    logic [N-1:0] gnt_oh_q, gnt_oh_d;

    logic [N-1:0] lo_req;
    logic [W-1:0] fix_idx, lo_idx, rr_idx, win_idx;
    logic         lo_any;
    logic [N-1:0] win_oh;
    logic         release_now;

    // Descending search from ptr wraps: the highest request at or below ptr wins,
    // otherwise the highest request overall (which must lie above ptr).
    for (genvar gi = 0; gi < N; gi++) begin : g_lo
        assign lo_req[gi] = req[gi] & (W'(gi) <= ptr_q);
        assign win_oh[gi] = (win_idx == W'(gi));
    end

    always_comb begin
        fix_idx = '0;
        lo_idx  = '0;
        lo_any  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fix_idx = W'(i);
            end
            if (lo_req[i]) begin
                lo_idx = W'(i);
                lo_any = 1'b1;
            end
        end
    end

    assign rr_idx      = lo_any ? lo_idx : fix_idx;
    assign win_idx     = mode ? rr_idx : fix_idx;
    assign release_now = done | ~req[gnt_idx_q];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mode_d      = mode_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_oh_d    = gnt_oh_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = BUSY;
                    mode_d      = mode;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = win_idx;
                    gnt_oh_d    = win_oh;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_d     = IDLE;
                    gnt_valid_d = 1'b0;
                    gnt_idx_d   = '0;
                    gnt_oh_d    = '0;
                    // The mode latched at arbitration decides whether the pointer moves.
                    if (mode_q) begin
                        ptr_d = (gnt_idx_q == '0) ? W'(N - 1) : gnt_idx_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= W'(N - 1);
            mode_q      <= 1'b0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            gnt_oh_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mode_q      <= mode_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_oh_q    <= gnt_oh_d;
        end
    end

    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_oh    = gnt_oh_q;

endmodule

// File: tb/tb_pri_arbiter_rr.sv
// Directed bench for pri_arbiter_rr (N = 8): reset, fixed walk, round-robin
// fairness, release by drop, hold/mode isolation and reset mid-grant.
module tb_pri_arbiter_rr;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         mode;
    logic         done;
    logic         gnt_valid;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt_oh;

    int errors = 0;
    int checks = 0;

    pri_arbiter_rr #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_oh    (gnt_oh)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic exp_valid, input int exp_idx);
        logic [N-1:0] exp_oh;
        exp_oh = exp_valid ? (N'(1) << exp_idx) : '0;
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(exp_valid));
        chk({tag, ".idx"},   32'(gnt_idx),   exp_valid ? 32'(exp_idx) : 32'd0);
        chk({tag, ".oh"},    32'(gnt_oh),    32'(exp_oh));
        $display("%-14s valid=%0d idx=%0d oh=%08b", tag, gnt_valid, gnt_idx, gnt_oh);
    endtask

    initial begin
        int rr_seq [8] = '{6, 5, 4, 3, 2, 1, 0, 7};
        logic [N-1:0] fix_req [4] = '{8'b0000_0001, 8'b0000_1000, 8'b0000_1111, 8'b1111_1111};
        int fix_exp [4] = '{0, 3, 3, 7};

        rst = 1'b1; req = 8'hFF; mode = 1'b1; done = 1'b0;

        // Reset held two cycles with all requests asserted
        tick();
        chk_grant("rst_cyc1", 1'b0, 0);
        tick();
        chk_grant("rst_cyc2", 1'b0, 0);
        rst = 1'b0;
        tick();
        chk_grant("first_rr", 1'b1, 7);
        done = 1'b1;
        tick();
        chk_grant("first_rel", 1'b0, 0);
        done = 1'b0;

        // Round-robin fairness with req held at all ones
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_grant($sformatf("rr_gnt%0d", k), 1'b1, rr_seq[k]);
            done = 1'b1;
            tick();
            chk_grant($sformatf("rr_gap%0d", k), 1'b0, 0);
            done = 1'b0;
        end
        req = '0;
        tick();
        chk_grant("idle_noreq", 1'b0, 0);

        // Fixed priority walk; ptr now 6 and must stay there
        mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req = fix_req[k];
            tick();
            chk_grant($sformatf("fix_gnt%0d", k), 1'b1, fix_exp[k]);
            done = 1'b1;
            tick();
            chk_grant($sformatf("fix_rel%0d", k), 1'b0, 0);
            done = 1'b0;
            req = '0;
            tick();
        end

        // Release by dropping the granted request line
        req = 8'b0010_0100;
        tick();
        chk_grant("drop_gnt5", 1'b1, 5);
        req = 8'b0000_0100;
        tick();
        chk_grant("drop_rel", 1'b0, 0);
        tick();
        chk_grant("drop_gnt2", 1'b1, 2);

        // Hold on idx 2 while req[7] rises and mode toggles
        req = 8'b1000_0100;
        mode = 1'b1;
        tick();
        chk_grant("hold_a", 1'b1, 2);
        mode = 1'b0;
        tick();
        chk_grant("hold_b", 1'b1, 2);
        mode = 1'b1;
        done = 1'b1;
        tick();
        chk_grant("hold_rel", 1'b0, 0);
        done = 1'b0;
        // mode=1 sampled now, ptr still 6 from fixed releases: 6..2 finds 2, not 7
        tick();
        chk_grant("mode_rr", 1'b1, 2);
        done = 1'b1;
        tick();
        chk_grant("mode_rel", 1'b0, 0);
        done = 1'b0;
        req = '0;
        tick();

        // ptr = 1: search 1,0,7,6,5,4 lands on 4
        req = 8'b0001_0000;
        tick();
        chk_grant("busy4", 1'b1, 4);
        req = 8'hFF;
        rst = 1'b1;
        done = 1'b1;
        tick();
        chk_grant("rst_mid", 1'b0, 0);
        rst = 1'b0;
        done = 1'b0;
        tick();
        chk_grant("post_rst", 1'b1, 7);

        // done and req[g] low together: one release, ptr 7 -> 6
        done = 1'b1;
        req = 8'b0111_1111;
        tick();
        chk_grant("dual_rel", 1'b0, 0);
        done = 1'b0;
        req = 8'hFF;
        tick();
        chk_grant("dual_next", 1'b1, 6);

        // done in IDLE is ignored
        done = 1'b1;
        tick();
        chk_grant("dual_next_rel", 1'b0, 0);
        req = '0;
        tick();
        chk_grant("idle_done", 1'b0, 0);
        done = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
